pm_sequencer: RTL and testbench

PM_SEQUENCER -- requirements
Module: pm_sequencer

---
 rtl/pm_sequencer.sv | 124 ++++++++++++
 tb/tb_pm_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pm_sequencer.sv
// rtl/pm_sequencer.sv - four-state instruction fetch/decode sequencer with a datapath handshake
module pm_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int PC_WIDTH   = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  STOP,
  output logic [PC_WIDTH-1:0]   PM_ADDR,
  input  logic [DATA_WIDTH-1:0] PM_DATA,
  output logic [3:0]            OPCODE,
  output logic [3:0]            REG_CODE,
  output logic [7:0]            IMM,
  output logic                  EXEC_VALID,
  input  logic                  EXEC_READY,
  output logic                  BUSY,
  output logic                  ILLEGAL
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DECODE = 2'd2,
    EXEC   = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP = 4'b1010;
  localparam logic [3:0] OP_JMP = 4'b1111;

  state_t                state, state_n;
  logic [PC_WIDTH-1:0]   pc, pc_n, pc_inc;
  logic [DATA_WIDTH-1:0] ir, ir_n;
  logic                  exec_valid, exec_valid_n;
  logic                  stop_pend, stop_pend_n;
  logic                  illegal, illegal_n;
  logic [3:0]            ir_op;

  assign pc_inc = pc + 1'b1;
  assign ir_op  = ir[15:12];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      pc         <= '0;
      ir         <= '0;
      exec_valid <= 1'b0;
      stop_pend  <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      ir         <= ir_n;
      exec_valid <= exec_valid_n;
      stop_pend  <= stop_pend_n;
      illegal    <= illegal_n;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    ir_n         = ir;
    exec_valid_n = exec_valid;
    stop_pend_n  = stop_pend;
    illegal_n    = illegal;
    case (state)
      IDLE: begin
        stop_pend_n = 1'b0;
        if (START) begin
          state_n = FETCH;
        end
      end
      FETCH: begin
        // A stop seen now or parked during the previous instruction ends the run here.
        if (STOP || stop_pend) begin
          state_n     = IDLE;
          stop_pend_n = 1'b0;
        end else begin
          ir_n    = PM_DATA;
          state_n = DECODE;
        end
      end
      DECODE: begin
        stop_pend_n = stop_pend | STOP;
        if (ir_op == OP_JMP) begin
          pc_n    = PC_WIDTH'(ir[7:3]);
          state_n = FETCH;
        end else if (ir_op == OP_NOP) begin
          pc_n    = pc_inc;
          state_n = FETCH;
        end else if (ir_op[3] == 1'b0) begin
          exec_valid_n = 1'b1;
          state_n      = EXEC;
        end else begin
          // Undefined opcodes flag the sticky error and then behave as NOP.
          illegal_n = 1'b1;
          pc_n      = pc_inc;
          state_n   = FETCH;
        end
      end
      EXEC: begin
        stop_pend_n = stop_pend | STOP;
        if (EXEC_READY) begin
          exec_valid_n = 1'b0;
          pc_n         = pc_inc;
          state_n      = FETCH;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign PM_ADDR    = pc;
  assign OPCODE     = ir[15:12];
  assign REG_CODE   = ir[11:8];
  assign IMM        = ir[7:0];
  assign EXEC_VALID = exec_valid;
  assign BUSY       = (state != IDLE);
  assign ILLEGAL    = illegal;

endmodule

// File: tb/tb_pm_sequencer.sv
// tb/tb_pm_sequencer.sv - scoreboard bench for pm_sequencer with directed program vectors
module tb_pm_sequencer;
  logic        CLK = 1'b0;
  logic        RST, START, STOP, EXEC_READY;
  logic [4:0]  PM_ADDR;
  logic [15:0] PM_DATA;
  logic [3:0]  OPCODE, REG_CODE;
  logic [7:0]  IMM;
  logic        EXEC_VALID, BUSY, ILLEGAL;

  logic [15:0] pm [32];
  logic [20:0] exp_q [$];
  int vectors = 0;
  int miscompares = 0;

  pm_sequencer #(.DATA_WIDTH(16), .PC_WIDTH(5)) dut (
    .CLK(CLK), .RST(RST), .START(START), .STOP(STOP),
    .PM_ADDR(PM_ADDR), .PM_DATA(PM_DATA),
    .OPCODE(OPCODE), .REG_CODE(REG_CODE), .IMM(IMM),
    .EXEC_VALID(EXEC_VALID), .EXEC_READY(EXEC_READY),
    .BUSY(BUSY), .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;
  assign PM_DATA = pm[PM_ADDR];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: every cycle a request is presented it must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (!RST && EXEC_VALID) begin
      if (exp_q.size() == 0) begin
        check("unexpected_exec_valid", 32'(EXEC_VALID), 32'd0);
      end else begin
        check("exec_fields", {11'd0, PM_ADDR, OPCODE, REG_CODE, IMM}, {11'd0, exp_q[0]});
        if (EXEC_READY) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) pm[i] = 16'hA000;
    pm[0]  = 16'h0105;
    pm[1]  = 16'hA000;
    pm[2]  = 16'hF0A0;
    pm[20] = 16'hF018;
    pm[3]  = 16'h132A;
    pm[4]  = 16'h8000;
    pm[5]  = 16'h6455;
    pm[6]  = 16'hF0F8;
    pm[31] = 16'hA000;

    RST = 1'b1; START = 1'b0; STOP = 1'b0; EXEC_READY = 1'b1;
    tick(); tick();
    check("rst_pm_addr", 32'(PM_ADDR), 32'd0);
    check("rst_fields", {20'd0, OPCODE, REG_CODE, IMM}, 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_valid_illegal", {30'd0, EXEC_VALID, ILLEGAL}, 32'd0);
    RST = 1'b0;
    tick();
    check("idle_hold_busy", 32'(BUSY), 32'd0);

    // ADD r1,#5 with ready tied high
    exp_q.push_back({5'd0, 16'h0105});
    START = 1'b1; tick(); START = 1'b0;
    check("start_fetch_busy", 32'(BUSY), 32'd1);
    check("start_fetch_addr", 32'(PM_ADDR), 32'd0);
    tick();
    check("decode_fields", {20'd0, OPCODE, REG_CODE, IMM}, 32'h0105);
    check("decode_no_valid", 32'(EXEC_VALID), 32'd0);
    tick();
    check("exec_valid_3rd", 32'(EXEC_VALID), 32'd1);
    tick();
    check("after_add_addr", 32'(PM_ADDR), 32'd1);
    check("after_add_valid", 32'(EXEC_VALID), 32'd0);

    tick(); tick();
    check("after_nop_addr", 32'(PM_ADDR), 32'd2);
    tick(); tick();
    check("jmp20_addr", 32'(PM_ADDR), 32'd20);
    tick(); tick();
    check("jmp3_addr", 32'(PM_ADDR), 32'd3);

    // SUB with a four-cycle stall
    exp_q.push_back({5'd3, 16'h132A});
    EXEC_READY = 1'b0;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      check("stall_valid", 32'(EXEC_VALID), 32'd1);
      check("stall_addr", 32'(PM_ADDR), 32'd3);
      if (i < 3) tick();
    end
    tick();
    EXEC_READY = 1'b1;
    check("stall5_valid", 32'(EXEC_VALID), 32'd1);
    tick();
    check("after_stall_addr", 32'(PM_ADDR), 32'd4);
    check("after_stall_valid", 32'(EXEC_VALID), 32'd0);

    // undefined opcode 0x8
    check("pre_illegal", 32'(ILLEGAL), 32'd0);
    tick(); tick();
    check("illegal_set", 32'(ILLEGAL), 32'd1);
    check("illegal_as_nop_addr", 32'(PM_ADDR), 32'd5);

    // LD with a STOP pulse during EXEC
    exp_q.push_back({5'd5, 16'h6455});
    tick(); tick();
    STOP = 1'b1; tick(); STOP = 1'b0;
    check("stop_pend_fetch_addr", 32'(PM_ADDR), 32'd6);
    check("stop_pend_fetch_busy", 32'(BUSY), 32'd1);
    tick();
    check("stopped_busy", 32'(BUSY), 32'd0);
    check("stopped_addr", 32'(PM_ADDR), 32'd6);
    tick(); tick();
    check("stopped_stays_idle", 32'(BUSY), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // resume at 6: JMP 31, then NOP wraps to 0
    START = 1'b1; tick(); START = 1'b0;
    check("resume_addr", 32'(PM_ADDR), 32'd6);
    check("resume_busy", 32'(BUSY), 32'd1);
    tick(); tick();
    check("jmp31_addr", 32'(PM_ADDR), 32'd31);
    tick(); tick();
    check("wrap_addr", 32'(PM_ADDR), 32'd0);
    check("illegal_sticky", 32'(ILLEGAL), 32'd1);

    // STOP in FETCH leaves IR and PC untouched
    STOP = 1'b1; tick(); STOP = 1'b0;
    check("fetch_stop_busy", 32'(BUSY), 32'd0);
    check("fetch_stop_addr", 32'(PM_ADDR), 32'd0);
    check("fetch_stop_ir", {20'd0, OPCODE, REG_CODE, IMM}, 32'hA000);

    // START and STOP together in IDLE: STOP is not retained
    exp_q.push_back({5'd0, 16'h0105});
    START = 1'b1; STOP = 1'b1; tick(); START = 1'b0; STOP = 1'b0;
    check("start_stop_busy", 32'(BUSY), 32'd1);
    EXEC_READY = 1'b0;
    tick();
    check("start_stop_decode", {20'd0, OPCODE, REG_CODE, IMM}, 32'h0105);
    tick();
    check("pre_rst_valid", 32'(EXEC_VALID), 32'd1);

    // reset in the middle of EXEC
    RST = 1'b1; tick();
    check("midrst_valid", 32'(EXEC_VALID), 32'd0);
    check("midrst_addr", 32'(PM_ADDR), 32'd0);
    check("midrst_illegal", 32'(ILLEGAL), 32'd0);
    check("midrst_busy", 32'(BUSY), 32'd0);
    check("midrst_fields", {20'd0, OPCODE, REG_CODE, IMM}, 32'd0);
    exp_q.delete();
    RST = 1'b0; EXEC_READY = 1'b1;
    tick(); tick();
    check("post_rst_idle", 32'(BUSY), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
